// File: rtl/phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its request/lamp-side neighbours.
// master drives detector and preemption inputs; slave is the scheduler itself.
interface phase_scheduler_if;
  logic [3:0] req_in;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] cur_phase;
  logic       preempt_ack;
  logic [3:0] pending;

  modport master (
    output req_in, preempt, preempt_phase,
    input  green, yellow, all_red, cur_phase, preempt_ack, pending
  );

  modport slave (
    input  req_in, preempt, preempt_phase,
    output green, yellow, all_red, cur_phase, preempt_ack, pending
  );
endinterface

// File: rtl/phase_scheduler.sv
// Demand-driven 4-phase intersection sequencer: round-robin service of latched requests,
// min/max green, yellow and all-red clearance, emergency preemption. All outputs registered.
module phase_scheduler #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  phase_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  localparam logic [7:0] MIN_G   = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G   = 8'(MAX_GREEN);
  localparam logic [7:0] Y_LAST  = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LAST = 8'(ALLRED_T - 1);

  state_t     state, next_state;
  logic [7:0] tmr, next_tmr;
  logic [1:0] cur_phase, next_phase;
  logic [3:0] pending, next_pending;
  logic [3:0] green, yellow;
  logic       all_red, preempt_ack;
  logic       enter_green;
  logic       others_pending;
  logic       leave_green;

  // Next phase to serve: first pending bit at cur+1, cur+2, cur+3, cur+0; else stay put.
  function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] pend);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (pend[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

  assign others_pending = |(pending & ~one_hot(cur_phase));
  assign leave_green =
      (bus.preempt && (bus.preempt_phase != cur_phase)) ||
      (!bus.preempt && (tmr >= MIN_G) && others_pending &&
       (!bus.req_in[cur_phase] || (tmr >= MAX_G)));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state   = state;
    next_tmr     = tmr;
    next_phase   = cur_phase;
    enter_green  = 1'b0;
    unique case (state)
      ST_ALL_RED: begin
        if (tmr == AR_LAST) begin
          next_state  = ST_GREEN;
          next_tmr    = 8'd1;
          enter_green = 1'b1;
          next_phase  = bus.preempt ? bus.preempt_phase : rr_pick(cur_phase, pending);
        end else begin
          next_tmr = tmr + 8'd1;
        end
      end
      ST_GREEN: begin
        if (leave_green) begin
          next_state = ST_YELLOW;
          next_tmr   = 8'd0;
        end else if (tmr != 8'hFF) begin
          next_tmr = tmr + 8'd1;
        end
      end
      ST_YELLOW: begin
        if (tmr == Y_LAST) begin
          next_state = ST_ALL_RED;
          next_tmr   = 8'd0;
        end else begin
          next_tmr = tmr + 8'd1;
        end
      end
      default: begin
        next_state = ST_ALL_RED;
        next_tmr   = 8'd0;
      end
    endcase

    // A request on the phase being (or about to be) served is absorbed by that green.
    next_pending = (pending | bus.req_in) & ~green;
    if (enter_green) next_pending[next_phase] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_ALL_RED;
      tmr         <= 8'd0;
      cur_phase   <= 2'd0;
      pending     <= 4'd0;
      green       <= 4'd0;
      yellow      <= 4'd0;
      all_red     <= 1'b1;
      preempt_ack <= 1'b0;
    end else begin
      state       <= next_state;
      tmr         <= next_tmr;
      cur_phase   <= next_phase;
      pending     <= next_pending;
      green       <= (next_state == ST_GREEN)  ? one_hot(next_phase) : 4'd0;
      yellow      <= (next_state == ST_YELLOW) ? one_hot(next_phase) : 4'd0;
      all_red     <= (next_state == ST_ALL_RED);
      preempt_ack <= (next_state == ST_GREEN) && bus.preempt &&
                     (next_phase == bus.preempt_phase);
    end
  end

  assign bus.green       = green;
  assign bus.yellow      = yellow;
  assign bus.all_red     = all_red;
  assign bus.cur_phase   = cur_phase;
  assign bus.preempt_ack = preempt_ack;
  assign bus.pending     = pending;

endmodule
